ps2_direction_decoder: RTL
==========================

// Module: ps2_direction_decoder
// PURPOSE
//  Receives PS/2 keyboard frames (scan-code set 2) and turns them into the
//  3-bit direction/reset command that drives the snake game core.
//  Sits between the board PS/2 pins and the snake core's direction input.
//  Handles make, break (F0) and extended (E0) codes for WASD, arrow keys and Space.
// PARAMETERS
//  FILTER_LEN   8      consecutive equal clk samples before ps2_clk changes state
//  TIMEOUT_CYC  80000  cycles with no ps2_clk fall mid-frame before abort (2 ms @ 40 MHz)
// PORTS
//  clk         in   1  system clock, 40 MHz pixel clock domain
//  rst_n       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data    in   1  raw PS/2 data pin (asynchronous)
//  direction   out  3  011=up 010=left 001=down 000=right 100=reset/idle
//  key_strobe  out  1  1-cycle pulse each time a mapped make code is accepted
//  scan_code   out  8  last correctly received byte (debug)
//  scan_valid  out  1  1-cycle pulse when scan_code updates
//  frame_err   out  1  1-cycle pulse on parity, stop-bit or timeout error
// BEHAVIOUR
//  - Reset: direction=3'b100, scan_code=8'h00, all pulses 0, RX=IDLE, brk/ext flags=0.
//  - Inputs pass through a 2-FF synchroniser. ps2_clk then goes through the FILTER_LEN debounce.
//    A bit is taken on a falling edge of the filtered clock; data comes from the synced ps2_data.
//  - RX FSM: IDLE -(fall, data=0)-> DATA; an IDLE fall with data=1 is ignored.
//    DATA: 8 bits, LSB first, 3-bit counter -> PARITY -> STOP -> IDLE.
//  - Frame check: odd parity over 8 data + parity bits; stop bit must be 1.
//    Good frame: scan_code updates and scan_valid pulses on the cycle after the stop-bit fall.
//    Bad frame: frame_err pulses, the byte is discarded, brk and ext clear.
//  - Timeout counter runs in DATA/PARITY/STOP and resets on every fall.
//    At TIMEOUT_CYC: frame_err pulses, FSM goes to IDLE, flags clear. No timeout in IDLE.
//  - Decoder runs on scan_valid.
//    E0 sets ext. F0 sets brk. Any other byte is a key; after it, brk and ext both clear.
//  - Key with brk=1: ignored (release). Key with brk=0 is a make code:
//    ext=0: 1D->011, 1C->010, 1B->001, 23->000, 29(Space)->100.
//    ext=1: 75->011, 6B->010, 72->001, 74->000.
//    Any other code: no change and no key_strobe.
//  - An accepted make code updates direction and pulses key_strobe in the same cycle,
//    which is 1 cycle after scan_valid. Total latency is 2 clk after the stop-bit fall.
//  - Typematic repeat of the current key: direction unchanged, key_strobe still pulses.
//  - Reset state (100) is left by any mapped direction key.
//    Space is always accepted, from any state.
//  - rst_n asserted mid-frame: immediate return to reset values; the partial frame is lost.
//  - The snake core treats direction=100 as a level reset. It stays 100 until a direction key.
// CONFIGURATION
//  NO_REVERSE_EN defined:
//    a make code that requests the 180-degree opposite of the current direction is dropped:
//    up<->down, left<->right. Direction unchanged, no key_strobe. Space and 100->any are unaffected.
//  NO_REVERSE_EN undefined: every mapped make code is accepted as described above.
// TESTING
//  1. Reset release -> direction=100, key_strobe=0, frame_err=0, scan_code=00.
//  2. Frame 1D (W), valid parity -> scan_code=1D, then direction=011 + one key_strobe 2 clk after stop.
//  3. Frames E0 6B, then E0 F0 6B -> direction=010 after the make, unchanged after the break, brk/ext cleared.
//  4. Frame 1C with parity flipped -> frame_err pulse, no scan_valid, direction unchanged.
//     Then frame 29 -> direction=100.
//  5. Start bit + 3 data bits, then ps2_clk idle for 80000 clk -> frame_err pulse, RX back to IDLE.
//     Next full frame 23 -> direction=000.
//  6. direction=011, frame 1B: NO_REVERSE_EN defined -> stays 011, no strobe.
//     NO_REVERSE_EN undefined -> 001 with strobe.

Source files
------------

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder
// Receives PS/2 scan-code set 2 frames and turns WASD, arrow and Space make
// codes into the 3-bit direction/reset command for the snake game core.
// The raw pins are synchronised and the PS/2 clock is debounced. An 11-bit
// frame receiver with parity, stop-bit and timeout checks feeds a make,
// break (F0) and extended (E0) decoder.
//
// Build option:
//   NO_REVERSE_EN - drop a make code that would turn the snake 180 degrees.

module ps2_direction_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] direction,
  output logic       key_strobe,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] DIR_RIGHT = 3'b000;
  localparam logic [2:0] DIR_DOWN  = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_IDLE  = 3'b100;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Map a key byte to a direction. Bit 3 of the result is the hit flag.
  function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
    logic [3:0] res;
    res = 4'b0000;
    if (!ext) begin
      case (code)
        8'h1D:   res = {1'b1, DIR_UP};
        8'h1C:   res = {1'b1, DIR_LEFT};
        8'h1B:   res = {1'b1, DIR_DOWN};
        8'h23:   res = {1'b1, DIR_RIGHT};
        8'h29:   res = {1'b1, DIR_IDLE};
        default: res = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h75:   res = {1'b1, DIR_UP};
        8'h6B:   res = {1'b1, DIR_LEFT};
        8'h72:   res = {1'b1, DIR_DOWN};
        8'h74:   res = {1'b1, DIR_RIGHT};
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             ps2_clk_s;
  logic             ps2_data_s;
  logic             clk_filt;
  logic [FCW-1:0]   filt_cnt;
  logic             clk_fall;
  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [TCW-1:0]   tmo_cnt;
  logic             tmo_hit;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic             par_q;
  logic             shift_en;
  logic             par_en;
  logic             frame_good;
  logic             frame_bad;
  logic             brk_q;
  logic             ext_q;
  logic             map_hit;
  logic [2:0]       map_dir;
  logic             make_ok;

  // Two-flop synchronisers; both lines reset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value regardless of statement order.
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign ps2_clk_s  = clk_sync[1];
  assign ps2_data_s = data_sync[1];

  // Debounce: the filtered clock follows only after FILTER_LEN differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (ps2_clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_filt <= ps2_clk_s;
        filt_cnt <= '0;
        clk_fall <= ~ps2_clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Mid-frame watchdog, restarted on every filtered falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state_q == RX_IDLE || clk_fall || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state_q != RX_IDLE) && !clk_fall && (tmo_cnt == TCW'(TIMEOUT_CYC - 1));

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  // RX next-state logic.
  always_comb begin
    // NOTE: default assignment up front so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (clk_fall && !ps2_data_s)    state_d = RX_DATA;
      RX_DATA:   if (clk_fall && bit_cnt == 3'd7) state_d = RX_PARITY;
      RX_PARITY: if (clk_fall)                   state_d = RX_STOP;
      RX_STOP:   if (clk_fall)                   state_d = RX_IDLE;
      default:                                   state_d = RX_IDLE;
    endcase
    if (tmo_hit) state_d = RX_IDLE;
  end

  // RX output decode: bit capture enables and frame verdicts.
  always_comb begin
    shift_en   = clk_fall && (state_q == RX_DATA);
    par_en     = clk_fall && (state_q == RX_PARITY);
    frame_good = 1'b0;
    frame_bad  = tmo_hit;
    if (clk_fall && state_q == RX_STOP) begin
      frame_good = (^{shift_q, par_q}) && ps2_data_s;
      frame_bad  = !frame_good;
    end
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 8'h00;
      bit_cnt <= 3'd0;
      par_q   <= 1'b0;
    end else begin
      if (state_q == RX_IDLE) bit_cnt <= 3'd0;
      else if (shift_en)      bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_q <= {ps2_data_s, shift_q[7:1]};
      if (par_en)   par_q   <= ps2_data_s;
    end
  end

  // Registered frame results, one cycle after the stop-bit fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= frame_good;
      frame_err  <= frame_bad;
      if (frame_good) scan_code <= shift_q;
    end
  end

  // Make-code acceptance for the byte presented on scan_valid.
  always_comb begin
    {map_hit, map_dir} = map_key(ext_q, scan_code);
    make_ok = scan_valid && !brk_q && map_hit &&
              (scan_code != CODE_EXT) && (scan_code != CODE_BRK);
`ifdef NO_REVERSE_EN
    // Opposite directions differ only in bit 1; Space and the idle state are exempt.
    if (!map_dir[2] && !direction[2] && ((map_dir[1:0] ^ direction[1:0]) == 2'b10))
      make_ok = 1'b0;
`endif
  end

  // Prefix flags, direction register and key strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      direction  <= DIR_IDLE;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= make_ok;
      if (make_ok) direction <= map_dir;
      if (frame_err) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (scan_valid) begin
        case (scan_code)
          CODE_EXT: ext_q <= 1'b1;
          CODE_BRK: brk_q <= 1'b1;
          default: begin
            brk_q <= 1'b0;
            ext_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
